// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor: local-history PHT, gshare PHT and per-PC chooser,
// with a speculative GHR checkpointed through D/E/M and repaired on mispredict.
module branch_predict_tournament #(
    parameter int PC_IDX_W = 8,
    parameter int LH_W     = 6,
    parameter int GHR_W    = 8,
    parameter int CTR_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        flushE,
    input  logic        flushM,
    input  logic        branchD,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        pred_chooseD,
    output logic        mispredM
);

    localparam int PC_N = 1 << PC_IDX_W;
    localparam int LH_N = 1 << LH_W;
    localparam int GH_N = 1 << GHR_W;
    localparam logic [CTR_W-1:0] CTR_RST = {1'b0, {(CTR_W-1){1'b1}}};

    typedef struct packed {
        logic [PC_IDX_W-1:0] pi;
        logic [GHR_W-1:0]    gi;
        logic [LH_W-1:0]     li;
        logic                lp;
        logic                gp;
        logic                ch;
        logic [GHR_W-1:0]    ghr;
    } snap_t;

    logic [LH_W-1:0]  r_lht  [PC_N];
    logic [CTR_W-1:0] r_lpht [LH_N];
    logic [CTR_W-1:0] r_gpht [GH_N];
    logic [CTR_W-1:0] r_cho  [PC_N];
    logic [GHR_W-1:0] r_ghr;

    snap_t r_d, r_e, r_m;
    logic  r_br_e, r_pt_e, r_br_m, r_pt_m;
    snap_t w_look;

    function automatic logic [CTR_W-1:0] f_sat(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (c == {CTR_W{1'b1}}) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    // F-stage lookup reads table state directly; M-stage writes land after this edge.
    always_comb begin
        w_look     = '0;
        w_look.pi  = pcF[PC_IDX_W+1:2];
        w_look.gi  = pcF[GHR_W+1:2] ^ r_ghr;
        w_look.li  = r_lht[w_look.pi];
        w_look.lp  = r_lpht[w_look.li][CTR_W-1];
        w_look.gp  = r_gpht[w_look.gi][CTR_W-1];
        w_look.ch  = r_cho[w_look.pi][CTR_W-1];
        w_look.ghr = r_ghr;
    end

    assign pred_chooseD = r_d.ch;
    assign pred_takeD   = r_d.ch ? r_d.gp : r_d.lp;
    assign mispredM     = r_br_m & (r_pt_m != actual_takeM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= '0;
            r_e    <= '0;
            r_m    <= '0;
            r_br_e <= 1'b0;
            r_pt_e <= 1'b0;
            r_br_m <= 1'b0;
            r_pt_m <= 1'b0;
        end else begin
            if (flushD)
                r_d <= '0;
            else if (!stallD)
                r_d <= w_look;

            if (flushE) begin
                r_e    <= '0;
                r_br_e <= 1'b0;
                r_pt_e <= 1'b0;
            end else begin
                r_e    <= r_d;
                r_br_e <= branchD;
                r_pt_e <= pred_takeD;
            end

            if (flushM) begin
                r_m    <= '0;
                r_br_m <= 1'b0;
                r_pt_m <= 1'b0;
            end else begin
                r_m    <= r_e;
                r_br_m <= r_br_e;
                r_pt_m <= r_pt_e;
            end
        end
    end

    // Repair outranks the D-stage shift: the D branch is on the wrong path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ghr <= '0;
        else if (mispredM)
            r_ghr <= {r_m.ghr[GHR_W-2:0], actual_takeM};
        else if (branchD && !stallD && !flushD)
            r_ghr <= {r_ghr[GHR_W-2:0], pred_takeD};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PC_N; i++) begin
                r_lht[i] <= '0;
                r_cho[i] <= CTR_RST;
            end
            for (int i = 0; i < LH_N; i++)
                r_lpht[i] <= CTR_RST;
            for (int i = 0; i < GH_N; i++)
                r_gpht[i] <= CTR_RST;
        end else if (r_br_m) begin
            r_lpht[r_m.li] <= f_sat(r_lpht[r_m.li], actual_takeM);
            r_gpht[r_m.gi] <= f_sat(r_gpht[r_m.gi], actual_takeM);
            r_lht[r_m.pi]  <= {r_lht[r_m.pi][LH_W-2:0], actual_takeM};
            if (r_m.lp != r_m.gp)
                r_cho[r_m.pi] <= f_sat(r_cho[r_m.pi], r_m.gp == actual_takeM);
        end
    end

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Randomized bench for branch_predict_tournament against an integer-array reference model.
module tb_branch_predict_tournament;

    localparam int PC_IDX_W = 8;
    localparam int LH_W     = 6;
    localparam int GHR_W    = 8;
    localparam int CTR_W    = 2;
    localparam int PC_N     = 1 << PC_IDX_W;
    localparam int LH_N     = 1 << LH_W;
    localparam int GH_N     = 1 << GHR_W;
    localparam int CMAX     = (1 << CTR_W) - 1;
    localparam int CHALF    = 1 << (CTR_W - 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic        stallD = 1'b0, flushD = 1'b0, flushE = 1'b0, flushM = 1'b0;
    logic        branchD = 1'b0, actual_takeM = 1'b0;
    logic        pred_takeD, pred_chooseD, mispredM;

    int checks = 0;
    int failures = 0;

    branch_predict_tournament #(
        .PC_IDX_W(PC_IDX_W), .LH_W(LH_W), .GHR_W(GHR_W), .CTR_W(CTR_W)
    ) dut (
        .clk(clk), .rst(rst), .pcF(pcF),
        .stallD(stallD), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .branchD(branchD), .actual_takeM(actual_takeM),
        .pred_takeD(pred_takeD), .pred_chooseD(pred_chooseD), .mispredM(mispredM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tables as plain ints, instructions tracked as D/E/M records.
    typedef struct {
        int pi, gi, li, lp, gp, ch, ghr, br, pt;
    } rec_t;

    int   lht [PC_N];
    int   lpht[LH_N];
    int   gpht[GH_N];
    int   cho [PC_N];
    int   ghr;
    int   alt [PC_N];
    rec_t md, me, mm;

    function automatic int sat(input int c, input int up);
        if (up != 0) return (c < CMAX) ? c + 1 : c;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int pred_of(input rec_t r);
        return (r.ch != 0) ? r.gp : r.lp;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PC_N; i++) begin lht[i] = 0; cho[i] = CHALF - 1; end
        for (int i = 0; i < LH_N; i++) lpht[i] = CHALF - 1;
        for (int i = 0; i < GH_N; i++) gpht[i] = CHALF - 1;
        ghr = 0;
        md = '{default: 0};
        me = '{default: 0};
        mm = '{default: 0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_pred_takeD", {31'd0, pred_takeD}, 0);
        chk("rst_pred_chooseD", {31'd0, pred_chooseD}, 0);
        chk("rst_mispredM", {31'd0, mispredM}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic [31:0] pc, input bit st, input bit fd,
                        input bit fe, input bit fm, input bit bd);
        rec_t lk, nd, ne, nm;
        int   a, mp, p;
        @(negedge clk);
        a = $urandom_range(0, 1);
        if (mm.br != 0) begin
            p = mm.pi;
            case (p % 4)
                0: a = 1;
                1: begin a = alt[p]; alt[p] = 1 - alt[p]; end
                2: a = 0;
                default: a = $urandom_range(0, 1);
            endcase
        end
        mp = (mm.br != 0 && mm.pt != a) ? 1 : 0;
        if (mp != 0) begin fd = 1; fe = 1; fm = 1; end

        pcF = pc; stallD = st; flushD = fd; flushE = fe; flushM = fm;
        branchD = bd; actual_takeM = a[0];
        #1;
        chk("pred_takeD", {31'd0, pred_takeD}, pred_of(md));
        chk("pred_chooseD", {31'd0, pred_chooseD}, md.ch);
        chk("mispredM", {31'd0, mispredM}, mp);

        lk.pi  = (pc >> 2) % PC_N;
        lk.gi  = ((pc >> 2) % GH_N) ^ ghr;
        lk.li  = lht[lk.pi];
        lk.lp  = (lpht[lk.li] >= CHALF) ? 1 : 0;
        lk.gp  = (gpht[lk.gi] >= CHALF) ? 1 : 0;
        lk.ch  = (cho[lk.pi] >= CHALF) ? 1 : 0;
        lk.ghr = ghr;
        lk.br  = 0;
        lk.pt  = 0;

        nd = fd ? '{default: 0} : (st ? md : lk);
        ne = md;
        ne.br = bd;
        ne.pt = pred_of(md);
        if (fe) ne = '{default: 0};
        nm = fm ? '{default: 0} : me;

        if (mm.br != 0) begin
            lpht[mm.li] = sat(lpht[mm.li], a);
            gpht[mm.gi] = sat(gpht[mm.gi], a);
            lht[mm.pi]  = ((lht[mm.pi] * 2) + a) % LH_N;
            if (mm.lp != mm.gp) cho[mm.pi] = sat(cho[mm.pi], (mm.gp == a) ? 1 : 0);
        end
        if (mp != 0)
            ghr = ((mm.ghr * 2) + a) % GH_N;
        else if (bd && !st && !fd)
            ghr = ((ghr * 2) + pred_of(md)) % GH_N;

        md = nd; me = ne; mm = nm;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return 32'h0040_0000 + ($urandom_range(0, 15) << 2);
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++)
            step(rand_pc(),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0);
    endtask

    initial begin
        for (int i = 0; i < PC_N; i++) alt[i] = 0;
        model_reset();
        do_reset();

        step(32'h0040_0010, 0, 0, 0, 0, 0);
        step(32'h0040_0010, 0, 0, 0, 0, 0);

        // Always-taken loop branch at one PC, back to back.
        for (int i = 0; i < 12; i++) step(32'h0040_0020, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)  step(32'h0040_0020, 0, 0, 0, 0, 0);

        // Alternating pattern at one PC, spaced so history settles between resolutions.
        for (int i = 0; i < 20; i++) begin
            step(32'h0040_0024, 0, 0, 0, 0, 1);
            for (int j = 0; j < 3; j++) step(32'h0040_0100, 0, 0, 0, 0, 0);
        end

        // flushD outranks stallD, with a branch in D.
        step(32'h0040_0020, 1, 1, 0, 0, 1);
        step(32'h0040_0020, 1, 0, 1, 0, 1);
        step(32'h0040_0020, 0, 0, 0, 0, 1);

        random_phase(3000);
        do_reset();
        step(32'h0040_0010, 0, 0, 0, 0, 0);
        random_phase(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
